// File: rtl/ddfs_pkg.sv
// rtl/ddfs_pkg.sv - shared states, mode encodings and default widths for the ddfs sweep controller
package ddfs_pkg;

    localparam int FW_W    = 10;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/ddfs_fw_step.sv
// rtl/ddfs_fw_step.sv - next sweep word toward a target, clamped, with at-target flag
module ddfs_fw_step #(
    parameter int FW_W = 10
) (
    input  logic [FW_W-1:0] cur,
    input  logic [FW_W-1:0] step,
    input  logic [FW_W-1:0] target,
    input  logic            up,
    output logic [FW_W-1:0] nxt,
    output logic            at_target
);

    logic [FW_W:0] step_eff;
    logic [FW_W:0] sum;
    logic [FW_W:0] diff;

    // One guard bit keeps the arithmetic from wrapping past either end of the word range.
    always_comb begin
        step_eff  = (step == '0) ? {{FW_W{1'b0}}, 1'b1} : {1'b0, step};
        sum       = {1'b0, cur} + step_eff;
        diff      = {1'b0, cur} - step_eff;
        at_target = (cur == target);
        nxt       = target;
        if (up) begin
            if (sum < {1'b0, target}) nxt = sum[FW_W-1:0];
        end else begin
            if (!diff[FW_W] && (diff[FW_W-1:0] > target)) nxt = diff[FW_W-1:0];
        end
    end

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// rtl/ddfs_sweep_ctrl.sv - frequency-word sweep sequencer for ddfs; DDFS_SWEEP_TRIANGLE_EN enables triangle mode
module ddfs_sweep_ctrl #(
    parameter int FW_W    = ddfs_pkg::FW_W,
    parameter int DWELL_W = ddfs_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FW_W-1:0]    cfg_start_fw,
    input  logic [FW_W-1:0]    cfg_stop_fw,
    input  logic [FW_W-1:0]    cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [FW_W-1:0]    manual_fw,
    output logic [FW_W-1:0]    fw,
    output logic               fw_upd,
    output logic               busy,
    output logic               done
);

    import ddfs_pkg::*;

    state_t             state;
    logic [FW_W-1:0]    start_sh;
    logic [FW_W-1:0]    stop_sh;
    logic [FW_W-1:0]    step_sh;
    logic [DWELL_W-1:0] dwell_sh;
    logic [1:0]         mode_sh;
    logic [DWELL_W-1:0] cnt;
    logic               dir_fwd;

    logic               up_sweep;
    logic               leg_up;
    logic [FW_W-1:0]    leg_target;
    logic [FW_W-1:0]    nxt_fw;
    logic               at_target;
    logic               is_single;
    logic               is_tri;

    always_comb begin
        up_sweep   = (stop_sh >= start_sh);
        leg_target = dir_fwd ? stop_sh : start_sh;
        leg_up     = dir_fwd ? up_sweep : !up_sweep;
        is_single  = (mode_sh == MODE_SINGLE) || (mode_sh == 2'd3);
    end

    ddfs_fw_step #(.FW_W(FW_W)) u_step (
        .cur       (fw),
        .step      (step_sh),
        .target    (leg_target),
        .up        (leg_up),
        .nxt       (nxt_fw),
        .at_target (at_target)
    );

`ifdef DDFS_SWEEP_TRIANGLE_EN
    logic [FW_W-1:0] rev_target;
    logic [FW_W-1:0] rev_fw;
    logic            rev_at;

    // Reverse leg evaluated in parallel so an endpoint is held once, not twice.
    assign rev_target = dir_fwd ? start_sh : stop_sh;
    assign is_tri     = (mode_sh == MODE_TRI);

    ddfs_fw_step #(.FW_W(FW_W)) u_rev (
        .cur       (fw),
        .step      (step_sh),
        .target    (rev_target),
        .up        (!leg_up),
        .nxt       (rev_fw),
        .at_target (rev_at)
    );
`else
    assign is_tri = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fw       <= '0;
            fw_upd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            dir_fwd  <= 1'b1;
            start_sh <= '0;
            stop_sh  <= '0;
            step_sh  <= '0;
            dwell_sh <= '0;
            mode_sh  <= MODE_SINGLE;
        end else begin
            fw_upd <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    fw      <= manual_fw;
                    dir_fwd <= 1'b1;
                    if (start && !abort) begin
                        start_sh <= cfg_start_fw;
                        stop_sh  <= cfg_stop_fw;
                        step_sh  <= cfg_step;
                        dwell_sh <= cfg_dwell;
                        mode_sh  <= cfg_mode;
                        fw       <= cfg_start_fw;
                        cnt      <= cfg_dwell;
                        fw_upd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        fw    <= manual_fw;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (!at_target) begin
                        fw     <= nxt_fw;
                        cnt    <= dwell_sh;
                        fw_upd <= 1'b1;
                    end else if (is_single) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef DDFS_SWEEP_TRIANGLE_EN
                    end else if (is_tri) begin
                        // rev_at here means start == stop: nothing to sweep, hold the word.
                        if (!rev_at) begin
                            dir_fwd <= !dir_fwd;
                            fw      <= rev_fw;
                            cnt     <= dwell_sh;
                            fw_upd  <= 1'b1;
                        end
`endif
                    end else if (start_sh != stop_sh) begin
                        fw      <= start_sh;
                        dir_fwd <= 1'b1;
                        cnt     <= dwell_sh;
                        fw_upd  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    fw    <= manual_fw;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// tb/tb_ddfs_sweep_ctrl.sv - scoreboard bench for ddfs_sweep_ctrl; honours DDFS_SWEEP_TRIANGLE_EN
module tb_ddfs_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  cfg_start_fw = '0;
    logic [9:0]  cfg_stop_fw = '0;
    logic [9:0]  cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic [9:0]  manual_fw = '0;
    logic [9:0]  fw;
    logic        fw_upd;
    logic        busy;
    logic        done;

    ddfs_sweep_ctrl #(.FW_W(10), .DWELL_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_start_fw (cfg_start_fw),
        .cfg_stop_fw  (cfg_stop_fw),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_mode     (cfg_mode),
        .manual_fw    (manual_fw),
        .fw           (fw),
        .fw_upd       (fw_upd),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [9:0] fw;
        int         at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (fw_upd || done)) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc=%0d fw=%h upd=%b done=%b, expected no event", cyc - base, fw, fw_upd, done);
            end else begin
                e = q.pop_front();
                if (fw_upd !== !e.is_done || done !== e.is_done || fw !== e.fw || busy !== !e.is_done || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL event: got fw=%h upd=%b done=%b busy=%b cyc=%0d, expected fw=%h done=%b cyc=%0d",
                             fw, fw_upd, done, busy, cyc - base, e.fw, e.is_done, e.at - base);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [9:0] s, input logic [9:0] p, input logic [9:0] st,
                          input logic [15:0] dw, input logic [1:0] md);
        cfg_start_fw = s;
        cfg_stop_fw  = p;
        cfg_step     = st;
        cfg_dwell    = dw;
        cfg_mode     = md;
        start        = 1'b1;
        base         = cyc;
    endtask

    task automatic go(input bit hold);
        @(negedge clk);
        if (!hold) begin
            start        = 1'b0;
            cfg_start_fw = 10'h2AA;
            cfg_stop_fw  = 10'h155;
            cfg_step     = 10'h003;
            cfg_dwell    = 16'd7;
            cfg_mode     = 2'd1;
        end
    endtask

    task automatic exp_w(input logic [9:0] v, input int off);
        q.push_back('{1'b0, v, base + off});
    endtask

    task automatic exp_d(input logic [9:0] v, input int off);
        q.push_back('{1'b1, v, base + off});
    endtask

    task automatic wait_cyc(input int off);
        while (cyc < base + off) @(negedge clk);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d events outstanding, expected 0", name, q.size());
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        manual_fw = 10'h155;
        repeat (3) @(negedge clk);
        check("rst_fw", fw, 0);
        check("rst_upd", fw_upd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("manual_a", fw, 10'h155);
        manual_fw = 10'h0AB;
        @(negedge clk);
        check("manual_b", fw, 10'h0AB);

        // single sweep with dwell 2
        launch(10'h010, 10'h040, 10'h010, 16'd2, 2'd0);
        exp_w(10'h010, 1); exp_w(10'h020, 4); exp_w(10'h030, 7); exp_w(10'h040, 10); exp_d(10'h040, 13);
        go(0);
        wait_cyc(2);
        check("single_busy", busy, 1);
        wait_cyc(14);
        check("single_manual", fw, 10'h0AB);
        drain("single", 4);

        launch(10'h000, 10'h025, 10'h010, 16'd0, 2'd0);
        exp_w(10'h000, 1); exp_w(10'h010, 2); exp_w(10'h020, 3); exp_w(10'h025, 4); exp_d(10'h025, 5);
        go(0);
        drain("clamp", 20);

        launch(10'h3F0, 10'h3FF, 10'h020, 16'd0, 2'd0);
        exp_w(10'h3F0, 1); exp_w(10'h3FF, 2); exp_d(10'h3FF, 3);
        go(0);
        drain("top_edge", 20);

        launch(10'h008, 10'h000, 10'h003, 16'd1, 2'd3);
        exp_w(10'h008, 1); exp_w(10'h005, 3); exp_w(10'h002, 5); exp_w(10'h000, 7); exp_d(10'h000, 9);
        go(0);
        drain("down", 20);

        launch(10'h005, 10'h007, 10'h000, 16'd0, 2'd0);
        exp_w(10'h005, 1); exp_w(10'h006, 2); exp_w(10'h007, 3); exp_d(10'h007, 4);
        go(0);
        drain("step0", 20);

        launch(10'h100, 10'h100, 10'h010, 16'd3, 2'd0);
        exp_w(10'h100, 1); exp_d(10'h100, 5);
        go(0);
        drain("equal", 20);

        // repeat mode, aborted after second pass begins
        launch(10'h010, 10'h040, 10'h010, 16'd2, 2'd1);
        exp_w(10'h010, 1); exp_w(10'h020, 4); exp_w(10'h030, 7); exp_w(10'h040, 10);
        exp_w(10'h010, 13); exp_w(10'h020, 16);
        go(0);
        wait_cyc(17);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("repeat_abort_busy", busy, 0);
        check("repeat_abort_fw", fw, 10'h0AB);
        drain("repeat", 4);

        launch(10'h010, 10'h030, 10'h010, 16'd0, 2'd2);
`ifdef DDFS_SWEEP_TRIANGLE_EN
        exp_w(10'h010, 1); exp_w(10'h020, 2); exp_w(10'h030, 3); exp_w(10'h020, 4); exp_w(10'h010, 5); exp_w(10'h020, 6);
`else
        exp_w(10'h010, 1); exp_w(10'h020, 2); exp_w(10'h030, 3); exp_w(10'h010, 4); exp_w(10'h020, 5); exp_w(10'h030, 6);
`endif
        go(0);
        wait_cyc(6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("tri_abort_busy", busy, 0);
        drain("triangle", 4);

        launch(10'h010, 10'h040, 10'h010, 16'd2, 2'd0);
        exp_w(10'h010, 1); exp_w(10'h020, 4);
        go(0);
        wait_cyc(5);
        manual_fw = 10'h077;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_fw", fw, 10'h077);
        repeat (16) @(negedge clk);
        drain("abort", 4);

        launch(10'h010, 10'h040, 10'h010, 16'd2, 2'd0);
        exp_w(10'h010, 1); exp_w(10'h020, 4);
        go(0);
        wait_cyc(5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fw", fw, 0);
        check("midrst_flags", {fw_upd, busy, done}, 0);
        rst = 1'b0;
        drain("midrst", 4);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_fw", fw, 10'h077);
        drain("start_abort", 4);

        // start held through DONE re-triggers a new sweep
        launch(10'h3F0, 10'h3FF, 10'h020, 16'd0, 2'd0);
        exp_w(10'h3F0, 1); exp_w(10'h3FF, 2); exp_d(10'h3FF, 3); exp_w(10'h3F0, 5);
        go(1);
        wait_cyc(5);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("retrig_busy", busy, 0);
        drain("retrig", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
